// File: rtl/icache_refill_if.sv
// Bundle of the miss, fill and RAM-port signals between the refill engine and its neighbours.
// Pure wiring: no latency of its own.
// Flow control is the engine's req/gnt handshake plus the rdy_in freeze carried outside.
interface icache_refill_if;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        busy;
    logic [31:0] fill_data;
    logic [31:0] fill_addr;
    logic        fill_we;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_din;

    // Refill engine side
    modport master (
        input  miss_valid, miss_addr, mem_gnt, mem_din,
        output busy, fill_data, fill_addr, fill_we, mem_req, mem_a, mem_wr
    );

    // Cache / arbiter / RAM side
    modport slave (
        output miss_valid, miss_addr, mem_gnt, mem_din,
        input  busy, fill_data, fill_addr, fill_we, mem_req, mem_a, mem_wr
    );
endinterface

// File: rtl/icache_refill.sv
// Fetches a missing 32-bit word as four RAM bytes and writes it back to the icache.
// Latency: fill_we 7 cycles after miss accept with immediate grant (+1 per grant-wait cycle).
// Backpressure: holds in REQ until mem_gnt; rdy_in=0 freezes everything. Macro REFILL_FLUSH_EN adds flush_in.
module icache_refill (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
`ifdef REFILL_FLUSH_EN
    input  logic             flush_in,
`endif
    icache_refill_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [1:0]  cnt_nxt;
    logic [31:0] base;
    logic [31:0] fill_data;
    logic        flush;
    logic        accept;
    logic        capture_en;
    logic [1:0]  cap_idx;
    logic [7:0]  cap_byte;
    // RAM keeps reading while we are frozen, so the byte that was valid on the
    // first stalled cycle is parked here until the capture actually happens.
    logic [7:0]  hold_byte;
    logic        hold_vld;
    logic        unused_addr_bits;

`ifdef REFILL_FLUSH_EN
    assign flush = flush_in;
`else
    assign flush = 1'b0;
`endif

    // Low address bits are dropped: refills are always word aligned.
    assign unused_addr_bits = ^bus.miss_addr[1:0];

    assign accept     = (state == IDLE) && bus.miss_valid && !flush;
    assign capture_en = ((state == ISSUE) && (cnt != 2'd0)) || (state == WAIT);
    assign cap_idx    = (state == WAIT) ? 2'd3 : (cnt - 2'd1);
    assign cap_byte   = hold_vld ? hold_byte : bus.mem_din;

    // Next-state and byte-counter logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = REQ;
                    cnt_nxt   = 2'd0;
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    state_nxt = ISSUE;
                    cnt_nxt   = 2'd0;
                end
            end
            ISSUE: begin
                if (cnt == 2'd3) begin
                    state_nxt = WAIT;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            WAIT:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A redirect abandons whatever refill is in flight.
        if (flush && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    // State and byte counter register, frozen while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else if (rdy_in) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Latch the word-aligned miss address; stays put for the whole refill
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            base <= 32'd0;
        end else if (rdy_in && accept) begin
            base <= {bus.miss_addr[31:2], 2'b00};
        end
    end

    // Assemble the little-endian word one byte per cycle
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fill_data <= 32'd0;
        end else if (rdy_in && capture_en) begin
            fill_data[{cap_idx, 3'b000} +: 8] <= cap_byte;
        end
    end

    // Park the in-flight RAM byte on the first frozen cycle of a capture slot
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hold_byte <= 8'd0;
            hold_vld  <= 1'b0;
        end else if (rdy_in) begin
            hold_vld <= 1'b0;
        end else if (capture_en && !hold_vld) begin
            hold_byte <= bus.mem_din;
            hold_vld  <= 1'b1;
        end
    end

    // base+cnt never carries past bit 1, so the sum is a plain concatenation.
    assign bus.mem_a     = {base[31:2], cnt};
    assign bus.mem_wr    = 1'b0;
    assign bus.busy      = (state != IDLE);
    assign bus.mem_req   = (state == REQ) || (state == ISSUE) || (state == WAIT);
    assign bus.fill_data = fill_data;
    assign bus.fill_addr = base;
    assign bus.fill_we   = (state == DONE) && !flush;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: byte RAM model, delayed-grant arbiter, fill scoreboard.
// Expected fills are queued when a miss is driven and checked when fill_we fires.
// Optional REFILL_FLUSH_EN steps are compiled in with the same macro.
module tb_icache_refill;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
`ifdef REFILL_FLUSH_EN
    logic flush_in;
`endif

    icache_refill_if bus();

    icache_refill dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
`ifdef REFILL_FLUSH_EN
        .flush_in (flush_in),
`endif
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    // Byte RAM with one-cycle read latency; keeps reading regardless of rdy_in
    logic [7:0] ram [0:65535];
    always @(posedge clk_in) bus.mem_din <= ram[bus.mem_a[15:0]];

    // Arbiter: grants after gnt_delay cycles of request, then holds grant
    int req_cnt = 0;
    int gnt_delay = 0;
    always @(posedge clk_in) req_cnt <= bus.mem_req ? req_cnt + 1 : 0;
    assign bus.mem_gnt = bus.mem_req && (req_cnt >= gnt_delay);

    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int w_snap = 0;
    logic [63:0] sbq [$];
    logic [63:0] mon_e;
    logic [31:0] trace [0:63];
    logic        trace_req [0:63];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [15:0] b;
        b = {a[15:2], 2'b00};
        return {ram[b + 16'd3], ram[b + 16'd2], ram[b + 16'd1], ram[b]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every counted fill_we must match the oldest queued miss
    always @(negedge clk_in) begin
        if (rst_in === 1'b1 && rdy_in === 1'b1 && bus.fill_we === 1'b1) begin
            we_cnt++;
            if (sbq.size() == 0) begin
                chk("spurious_fill_we", {31'd0, bus.fill_we}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_fill_addr", bus.fill_addr, mon_e[63:32]);
                chk("sb_fill_data", bus.fill_data, mon_e[31:0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #2;
    endtask

    task automatic start_miss(input logic [31:0] a);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = a;
        sbq.push_back({a & 32'hFFFF_FFFC, word_at(a)});
    endtask

    // Runs cycles after the accept cycle until fill_we; returns at the fill cycle.
    task automatic wait_fill(input string tag, input int exp_lat, input int stall_at,
                             input int stall_len, input bit keep, input logic [31:0] next_a);
        int k;
        int w0;
        w0 = we_cnt;
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            cyc();
            k = i;
            if (i == 1 && keep) start_miss(next_a);
            if (i == 2 && !keep) bus.miss_valid = 1'b0;
            if (stall_len > 0 && i == stall_at) rdy_in = 1'b0;
            if (stall_len > 0 && i == stall_at + stall_len) rdy_in = 1'b1;
            @(negedge clk_in);
            trace[i]     = bus.mem_a;
            trace_req[i] = bus.mem_req;
            if (bus.fill_we === 1'b1 && rdy_in === 1'b1) break;
        end
        #1;
        chk({tag, "_latency"}, k, exp_lat);
        chk({tag, "_we_once"}, we_cnt - w0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in         = 1'b0;
        rdy_in         = 1'b1;
        bus.miss_valid = 1'b0;
        bus.miss_addr  = 32'd0;
`ifdef REFILL_FLUSH_EN
        flush_in       = 1'b0;
`endif
        for (int i = 0; i < 65536; i++) begin
            ram[i] = i[7:0] ^ i[15:8] ^ 8'hA5;
        end
        ram[16'h1000] = 8'h13;
        ram[16'h1001] = 8'h05;
        ram[16'h1002] = 8'h10;
        ram[16'h1003] = 8'h00;

        // Reset state
        repeat (3) cyc();
        @(negedge clk_in);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_a", bus.mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("rst_fill_we", {31'd0, bus.fill_we}, 32'd0);
        chk("rst_fill_data", bus.fill_data, 32'd0);
        chk("rst_fill_addr", bus.fill_addr, 32'd0);
        cyc();
        rst_in = 1'b1;
        cyc();

        // Basic read, immediate grant
        cyc();
        start_miss(32'h0000_1002);
        @(negedge clk_in);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        wait_fill("basic", 7, 0, 0, 1'b0, 32'd0);
        chk("basic_data", bus.fill_data, 32'h0010_0513);
        chk("basic_addr", bus.fill_addr, 32'h0000_1000);
        for (int i = 2; i <= 5; i++) chk("basic_mem_a", trace[i], 32'h0000_1000 + 32'(i - 2));
        chk("basic_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        cyc();
        @(negedge clk_in);
        chk("post_done_busy", {31'd0, bus.busy}, 32'd0);

        // Grant withheld for five cycles
        gnt_delay = 5;
        cyc();
        start_miss(32'h0000_1104);
        @(negedge clk_in);
        wait_fill("gnt_delay", 12, 0, 0, 1'b0, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            chk("gnt_wait_mem_a", trace[i], 32'h0000_1104);
            chk("gnt_wait_mem_req", {31'd0, trace_req[i]}, 32'd1);
        end
        gnt_delay = 0;

        // rdy_in low for three cycles at ISSUE cnt=2
        cyc();
        start_miss(32'h0000_1000);
        @(negedge clk_in);
        wait_fill("stall", 10, 4, 3, 1'b0, 32'd0);
        for (int i = 4; i <= 7; i++) chk("stall_mem_a", trace[i], 32'h0000_1002);
        chk("stall_data", bus.fill_data, 32'h0010_0513);

        // New miss presented while busy is ignored until after DONE
        cyc();
        start_miss(32'h0000_1001);
        @(negedge clk_in);
        wait_fill("busy_first", 7, 0, 0, 1'b1, 32'h0000_2000);
        chk("busy_first_addr", bus.fill_addr, 32'h0000_1000);
        wait_fill("busy_second", 8, 0, 0, 1'b0, 32'd0);
        chk("busy_second_addr", bus.fill_addr, 32'h0000_2000);

        // Asynchronous reset in the middle of ISSUE
        cyc();
        start_miss(32'h0000_1200);
        @(negedge clk_in);
        cyc();
        bus.miss_valid = 1'b0;
        cyc();
        cyc();
        #1;
        rst_in = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("arst_mem_a", bus.mem_a, 32'd0);
        chk("arst_fill_we", {31'd0, bus.fill_we}, 32'd0);
        chk("arst_fill_data", bus.fill_data, 32'd0);
        chk("arst_fill_addr", bus.fill_addr, 32'd0);
        sbq.delete();
        w_snap = we_cnt;
        cyc();
        cyc();
        rst_in = 1'b1;
        repeat (5) cyc();
        @(negedge clk_in);
        #1;
        chk("arst_no_fill", we_cnt - w_snap, 0);
        chk("arst_idle", {31'd0, bus.busy}, 32'd0);
        cyc();
        start_miss(32'h0000_1000);
        @(negedge clk_in);
        wait_fill("after_reset", 7, 0, 0, 1'b0, 32'd0);
        chk("after_reset_data", bus.fill_data, 32'h0010_0513);

`ifdef REFILL_FLUSH_EN
        // Flush while in WAIT: refill dropped, no write
        w_snap = we_cnt;
        cyc();
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h0000_1000;
        @(negedge clk_in);
        cyc();
        bus.miss_valid = 1'b0;
        for (int i = 2; i <= 6; i++) cyc();
        flush_in = 1'b1;
        @(negedge clk_in);
        chk("flush_wait_req", {31'd0, bus.mem_req}, 32'd1);
        cyc();
        flush_in = 1'b0;
        @(negedge clk_in);
        chk("flush_wait_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_wait_req_drop", {31'd0, bus.mem_req}, 32'd0);
        chk("flush_wait_we", {31'd0, bus.fill_we}, 32'd0);

        // Flush in the DONE cycle suppresses the write strobe
        cyc();
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h0000_1000;
        @(negedge clk_in);
        cyc();
        bus.miss_valid = 1'b0;
        for (int i = 2; i <= 6; i++) cyc();
        @(negedge clk_in);
        chk("flush_done_pre_busy", {31'd0, bus.busy}, 32'd1);
        cyc();
        flush_in = 1'b1;
        #1;
        chk("flush_done_we", {31'd0, bus.fill_we}, 32'd0);
        cyc();
        flush_in = 1'b0;
        repeat (3) cyc();
        @(negedge clk_in);
        #1;
        chk("flush_no_fill", we_cnt - w_snap, 0);
        chk("flush_idle", {31'd0, bus.busy}, 32'd0);
`endif

        cyc();
        chk("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
# icache_refill

Miss-service engine on the memory side of the instruction cache. Accepts a miss address from the fetch/cache pair, wins the shared RAM port from the memory arbiter, and reads four bytes over the byte-wide RAM bus. It then presents one assembled little-endian word, with a one-cycle write strobe, back to the instruction cache. It is the reader counterpart that produces the cache's rewrite data and write enable.

## Interface
- No parameters.
- clk_in  input  1  system clock; all state on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; low freezes all state and outputs.
- miss_valid  input  1  cache miss pending (cache hit low and fetch active).
- miss_addr  input  32  missing instruction address; bits [1:0] ignored.
- busy  output  1  refill in progress (any state other than IDLE).
- fill_data  output  32  assembled instruction word (to cache rewrite data).
- fill_addr  output  32  word-aligned address of fill_data.
- fill_we  output  1  one-cycle write strobe to cache.
- mem_req  output  1  request for RAM port to arbiter.
- mem_gnt  input  1  arbiter grant; held high by the arbiter while mem_req is high.
- mem_a  output  32  RAM byte address.
- mem_wr  output  1  RAM write enable; constant 0.
- mem_din  input  8  RAM read data; valid one cycle after mem_a.

## Operation
- States: IDLE, REQ, ISSUE (byte counter cnt 0..3), WAIT, DONE.
- IDLE:
  - busy=0, mem_req=0.
  - On miss_valid=1, latch base={miss_addr[31:2],2'b00} and go to REQ.
- REQ:
  - mem_req=1.
  - On mem_gnt=1, go to ISSUE with cnt=0.
  - Otherwise stay in REQ.
- ISSUE:
  - mem_a=base+cnt.
  - Byte cnt-1 is captured from mem_din into fill_data[8*(cnt-1)+:8] when cnt>0.
  - cnt increments each cycle; after cnt=3, go to WAIT.
- WAIT:
  - Captures byte 3 into fill_data[31:24].
  - Go to DONE.
- DONE:
  - fill_we=1, fill_addr=base, mem_req=0.
  - Next state IDLE.
- mem_req is high from REQ through WAIT inclusive.
- mem_gnt is examined only in REQ.
- miss_valid and miss_addr are ignored while busy=1. base is stable for the whole refill.
- mem_wr is tied 0; this block never writes RAM.
- Address arithmetic is 32-bit. base+cnt never carries out of bits [1:0].
- Reset (rst_in=0, any time, including mid-refill):
  - State goes to IDLE immediately; the partial word is discarded.
  - Outputs: busy=0, mem_req=0, mem_a=0, mem_wr=0, fill_we=0, fill_data=0, fill_addr=0.

## Timing
- Let t be the cycle mem_gnt is sampled high in REQ.
- Addresses base+0..base+3 are driven in cycles t+1..t+4.
- Bytes are captured in cycles t+2..t+5.
- fill_we is high in cycle t+6 only.
- Latency from miss_valid accepted in IDLE (cycle s) to fill_we, with immediate grant: 7 cycles (fill_we at s+7).
- After DONE the block is in IDLE. A new miss can be accepted the cycle after fill_we; back-to-back refills have no gap beyond that.
- rdy_in=0:
  - State, cnt, captured bytes and all outputs hold.
  - A fill_we pulse in progress is held, and occurs exactly once when counted in rdy_in=1 cycles.
  - All latencies count rdy_in=1 cycles only.

## Configuration
- REFILL_FLUSH_EN: adds input flush_in (1 bit), driven by branch-mispredict redirect.
- With the macro defined:
  - flush_in=1 in any non-IDLE state returns the block to IDLE on the next edge, with mem_req dropped.
  - fill_we is gated combinationally: fill_we = (state==DONE) && !flush_in, so a flush in the DONE cycle suppresses the write.
  - flush_in in IDLE has no effect; a simultaneous miss_valid is ignored that cycle.
- Without the macro: no flush_in port; every accepted miss completes with exactly one fill_we.

## Test plan
- Basic read: RAM bytes at 0x1000..0x1003 = 13,05,10,00; miss_addr=0x1002, immediate grant -> mem_a steps 0x1000..0x1003, fill_we once, fill_data=0x00100513, fill_addr=0x1000.
- Grant delay: mem_gnt held low 5 cycles after REQ entry -> mem_req stays high, mem_a unchanged, fill_we exactly 5 cycles later than in the immediate-grant case.
- Stall: rdy_in low for 3 cycles during ISSUE cnt=2 -> mem_a holds base+2; fill_data identical to the unstalled run; fill_we once.
- Busy ignore: miss_addr changes to 0x2000 with miss_valid high mid-refill -> fill_addr stays at the original base; a second refill at 0x2000 starts only after DONE.
- Async reset: rst_in low mid-ISSUE between clock edges -> all outputs 0 immediately; no fill_we after release; next miss refills correctly.
- Flush (REFILL_FLUSH_EN): flush_in pulsed in WAIT -> IDLE next cycle, mem_req=0, no fill_we; flush_in in the DONE cycle -> fill_we=0.
